flit_send_arbiter: RTL and testbench

Shares one network send port (flit injection plus credit return) among NUM_REQ device-side requesters. Each requester presents flits tagged with a virtual channel. The block keeps one credit counter per VC and grants round-robin among requesters whose target VC has credit. Multi-flit packets can optionally be held atomically on the port. It sits between device adapters and a router's send_ports interface, in place of a single-source injection FIFO controller.

---
 rtl/flit_send_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_flit_send_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_send_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flit_send_arbiter
// Description : Shares one router send port among NUM_REQ requesters.
//               Keeps one credit counter per VC and grants round-robin
//               among requesters whose target VC has credit. Flit
//               acceptance and injection happen in the same cycle.
//               Optional macro FLIT_ARB_PACKET_LOCK_EN holds the port
//               for one requester until its packet tail has been sent.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_send_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int VC_BITS    = 2,
  parameter int FLIT_WIDTH = 261,
  parameter int CREDITS    = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ*VC_BITS-1:0]    req_vc,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [FLIT_WIDTH-1:0]         send_ports_putFlit_flit_in,
  output logic                          EN_send_ports_putFlit,
  input  logic [VC_BITS:0]              send_ports_getCredits,
  output logic                          EN_send_ports_getCredits,
  output logic                          err_credit_overflow
);

  localparam int c_NUM_VCS = 2**VC_BITS;
  localparam int c_CW      = $clog2(CREDITS) + 1;
  localparam int c_IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [c_CW-1:0] c_CREDITS_MAX = c_CW'(CREDITS);
  localparam logic [c_CW-1:0] c_CREDIT_ONE  = c_CW'(1);
  localparam logic [c_IW-1:0] c_RR_RESET    = c_IW'(NUM_REQ - 1);

  // Per-requester views of the flattened input buses (flit without its valid MSB)
  logic [FLIT_WIDTH-2:0] w_flit [NUM_REQ];
  logic [VC_BITS-1:0]    w_vc   [NUM_REQ];

  // Arbitration
  logic [NUM_REQ-1:0]    w_lock_mask;
  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_gnt_found;
  logic [c_IW-1:0]       w_gnt_idx;
  logic                  w_fire;
  logic [VC_BITS-1:0]    w_gnt_vc;
  logic [FLIT_WIDTH-2:0] w_gnt_flit;
  logic [c_IW-1:0]       r_rr_ptr;

  // Credit tracking
  logic                  w_ret_valid;
  logic [VC_BITS-1:0]    w_ret_vc;
  logic [c_NUM_VCS-1:0]  w_send_hit;
  logic [c_NUM_VCS-1:0]  w_ret_hit;
  logic [c_CW-1:0]       r_credit     [c_NUM_VCS];
  logic [c_CW-1:0]       w_credit_nxt [c_NUM_VCS];
  logic                  w_ovf_evt;
  logic                  r_err_ovf;

  // The flit MSB is replaced by our own valid bit; req_last is only
  // consulted when packet locking is built in.
  logic                  w_unused;
  assign w_unused = ^{req_flit, req_last};

  // --------------------------------------------------------------------------
  // Slice the flattened requester buses and form eligibility
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign w_flit[i] = req_flit[i*FLIT_WIDTH +: FLIT_WIDTH-1];
    assign w_vc[i]   = req_vc[i*VC_BITS +: VC_BITS];
    assign w_elig[i] = req_valid[i] && (r_credit[w_vc[i]] != '0) && w_lock_mask[i];
  end

`ifdef FLIT_ARB_PACKET_LOCK_EN
  // --------------------------------------------------------------------------
  // Packet lock: once a non-tail flit is sent, only its owner may use the
  // port until the owner's tail flit goes out.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t     r_lock_state;
  logic [c_IW-1:0] r_lock_idx;
  logic            w_lock_active;

  assign w_lock_active = (r_lock_state == ST_LOCKED);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lock_mask
    assign w_lock_mask[i] = !w_lock_active || (r_lock_idx == c_IW'(i));
  end

  // Lock FSM: enter on a non-tail fire, leave when the owner's tail fires
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lock_state <= ST_IDLE;
      r_lock_idx   <= '0;
    end else begin
      case (r_lock_state)
        ST_IDLE: begin
          if (w_fire && !req_last[w_gnt_idx]) begin
            r_lock_state <= ST_LOCKED;
            r_lock_idx   <= w_gnt_idx;
          end
        end
        ST_LOCKED: begin
          // Only the owner is eligible here, so any fire is the owner's.
          if (w_fire && req_last[w_gnt_idx]) begin
            r_lock_state <= ST_IDLE;
          end
        end
        default: begin
          r_lock_state <= ST_IDLE;
        end
      endcase
    end
  end
`else
  // Flit-level arbitration: every requester competes on every cycle
  assign w_lock_mask = '1;
`endif

  // --------------------------------------------------------------------------
  // Round-robin pick: first eligible index after the last granted one
  // --------------------------------------------------------------------------
  // Scan rr_ptr+1 .. rr_ptr+NUM_REQ (mod NUM_REQ) and take the first hit
  always_comb begin
    int idx;
    idx         = 0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = r_rr_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!w_gnt_found && w_elig[c_IW'(idx)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = c_IW'(idx);
      end
    end
  end

  // Reset gates the handshake combinationally so it drops without a clock
  assign w_fire     = w_gnt_found && !RST;
  assign w_gnt_vc   = w_vc[w_gnt_idx];
  assign w_gnt_flit = w_flit[w_gnt_idx];

  // One-hot ready to the granted requester only
  always_comb begin
    req_ready = '0;
    if (w_fire) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign EN_send_ports_putFlit      = w_fire;
  assign send_ports_putFlit_flit_in = {w_fire, w_gnt_flit};
  assign EN_send_ports_getCredits   = !RST;
  assign err_credit_overflow        = r_err_ovf;

  // --------------------------------------------------------------------------
  // Credit accounting
  // --------------------------------------------------------------------------
  assign w_ret_valid = send_ports_getCredits[VC_BITS];
  assign w_ret_vc    = send_ports_getCredits[VC_BITS-1:0];

  for (genvar v = 0; v < c_NUM_VCS; v++) begin : g_vc_hit
    assign w_send_hit[v] = w_fire      && (w_gnt_vc == VC_BITS'(v));
    assign w_ret_hit[v]  = w_ret_valid && (w_ret_vc == VC_BITS'(v));
  end

  // Next credit per VC; a send and a return on the same VC cancel out,
  // and a return to a full counter is dropped and flagged
  always_comb begin
    w_ovf_evt = 1'b0;
    for (int v = 0; v < c_NUM_VCS; v++) begin
      w_credit_nxt[v] = r_credit[v];
      if (w_send_hit[v] && !w_ret_hit[v]) begin
        w_credit_nxt[v] = r_credit[v] - c_CREDIT_ONE;
      end else if (w_ret_hit[v] && !w_send_hit[v]) begin
        if (r_credit[v] == c_CREDITS_MAX) begin
          w_ovf_evt = 1'b1;
        end else begin
          w_credit_nxt[v] = r_credit[v] + c_CREDIT_ONE;
        end
      end
    end
  end

  // Credit counters, round-robin pointer and sticky overflow flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int v = 0; v < c_NUM_VCS; v++) begin
        r_credit[v] <= c_CREDITS_MAX;
      end
      r_rr_ptr  <= c_RR_RESET;
      r_err_ovf <= 1'b0;
    end else begin
      for (int v = 0; v < c_NUM_VCS; v++) begin
        r_credit[v] <= w_credit_nxt[v];
      end
      if (w_fire) begin
        r_rr_ptr <= w_gnt_idx;
      end
      if (w_ovf_evt) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flit_send_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flit_send_arbiter
// Description : Scoreboard bench for flit_send_arbiter. A stimulus process
//               drives each cycle and queues the reference model's expected
//               port response; a monitor pops and compares on the falling
//               clock edge. Build with FLIT_ARB_PACKET_LOCK_EN to exercise
//               the packet-lock variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flit_send_arbiter;

  localparam int NUM_REQ = 4;
  localparam int VC_BITS = 2;
  localparam int FW      = 261;
  localparam int CREDITS = 8;
  localparam int NUM_VCS = 4;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic [NUM_REQ*FW-1:0]    req_flit = '0;
  logic [NUM_REQ*VC_BITS-1:0] req_vc = '0;
  logic [NUM_REQ-1:0]       req_last = '0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [FW-1:0]            flit_out;
  logic                     en_put;
  logic [VC_BITS:0]         get_credits = '0;
  logic                     en_get;
  logic                     err_ovf;

  flit_send_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .VC_BITS    (VC_BITS),
    .FLIT_WIDTH (FW),
    .CREDITS    (CREDITS)
  ) dut (
    .CLK                        (CLK),
    .RST                        (RST),
    .req_flit                   (req_flit),
    .req_vc                     (req_vc),
    .req_last                   (req_last),
    .req_valid                  (req_valid),
    .req_ready                  (req_ready),
    .send_ports_putFlit_flit_in (flit_out),
    .EN_send_ports_putFlit      (en_put),
    .send_ports_getCredits      (get_credits),
    .EN_send_ports_getCredits   (en_get),
    .err_credit_overflow        (err_ovf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit            en;
    bit [NUM_REQ-1:0] ready;
    logic [FW-1:0] flit;
    bit            getc;
    bit            err;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state: plain counters and a pointer, spec-level
  int m_credit[NUM_VCS];
  int m_last;
  bit m_locked;
  int m_owner;
  bit m_err;

  task automatic chk(input string name, input int c, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_flit();
    logic [FW-1:0] r;
    for (int b = 0; b < FW; b++) r[b] = 1'($urandom);
    return r;
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < NUM_VCS; v++) m_credit[v] = CREDITS;
    m_last   = NUM_REQ - 1;
    m_locked = 0;
    m_owner  = 0;
    m_err    = 0;
  endfunction

  // rmode: 0 = normal, 1 = reset held through the cycle, 2 = reset asserted mid-cycle
  task automatic drive_cycle(input bit [NUM_REQ-1:0] valid, input bit [NUM_REQ*VC_BITS-1:0] vcs,
                             input bit [NUM_REQ-1:0] last, input bit ret_v, input int ret_vc,
                             input int rmode, output int gnt);
    logic [FW-1:0] fl [NUM_REQ];
    exp_t e;
    int   c, vg;
    @(posedge CLK);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      fl[i] = rand_flit();
      req_flit[i*FW +: FW] = fl[i];
    end
    req_valid   = valid;
    req_vc      = vcs;
    req_last    = last;
    get_credits = {ret_v, VC_BITS'(ret_vc)};
    RST         = (rmode == 1);

    gnt   = -1;
    e.cyc = cyc;
    if (rmode != 0) begin
      e.en = 0; e.ready = '0; e.flit = '0; e.getc = 0; e.err = 0;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_last + k) % NUM_REQ;
        if (gnt < 0 && valid[c] && m_credit[vcs[c*VC_BITS +: VC_BITS]] > 0 && (!m_locked || c == m_owner))
          gnt = c;
      end
      e.getc  = 1;
      e.err   = m_err;
      e.en    = (gnt >= 0);
      e.ready = '0;
      e.flit  = '0;
      if (gnt >= 0) begin
        e.ready[gnt] = 1'b1;
        e.flit = {1'b1, fl[gnt][FW-2:0]};
      end
    end
    q.push_back(e);

    if (rmode == 2) begin
      #2 RST = 1'b1;
      #1;
      chk("async_rst_en", cyc, FW'(en_put), '0);
      chk("async_rst_ready", cyc, FW'(req_ready), '0);
      chk("async_rst_getc", cyc, FW'(en_get), '0);
    end

    // State after this cycle's rising edge
    if (rmode != 0) begin
      model_reset();
    end else begin
      vg = (gnt >= 0) ? int'(vcs[gnt*VC_BITS +: VC_BITS]) : -1;
      for (int v = 0; v < NUM_VCS; v++) begin
        if (vg == v && !(ret_v && ret_vc == v)) m_credit[v]--;
        else if (ret_v && ret_vc == v && vg != v) begin
          if (m_credit[v] == CREDITS) m_err = 1;
          else m_credit[v]++;
        end
      end
      if (gnt >= 0) begin
        m_last = gnt;
`ifdef FLIT_ARB_PACKET_LOCK_EN
        if (!m_locked && !last[gnt]) begin
          m_locked = 1;
          m_owner  = gnt;
        end else if (m_locked && last[gnt]) begin
          m_locked = 0;
        end
`endif
      end
    end
  endtask

  // Monitor: compare the port against the queued expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("put_en", e.cyc, FW'(en_put), FW'(e.en));
        chk("ready", e.cyc, FW'(req_ready), FW'(e.ready));
        chk("getc_en", e.cyc, FW'(en_get), FW'(e.getc));
        chk("err_ovf", e.cyc, FW'(err_ovf), FW'(e.err));
        if (e.en) chk("flit", e.cyc, flit_out, e.flit);
        else      chk("flit_msb", e.cyc, FW'(flit_out[FW-1]), '0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int g, s0, s1, rm;
    bit [NUM_REQ-1:0] lst;

    // Reset asserted at time zero with requests offered
    req_valid = '1;
    #2;
    chk("reset_en", 0, FW'(en_put), '0);
    chk("reset_ready", 0, FW'(req_ready), '0);
    chk("reset_getc", 0, FW'(en_get), '0);
    chk("reset_err", 0, FW'(err_ovf), '0);
    model_reset();
    repeat (2) drive_cycle('1, '0, '1, 0, 0, 1, g);

    // All four on VC0: 0,1,2,3,0,1,2,3 then starved
    repeat (10) drive_cycle('1, '0, '1, 0, 0, 0, g);

    // Return on VC0 while starved: usable next cycle only
    drive_cycle('1, '0, '1, 1, 0, 0, g);
    repeat (2) drive_cycle('1, '0, '1, 0, 0, 0, g);

    // Bring VC0 to 3, then send and return together: stays at 3
    repeat (3) drive_cycle('0, '0, '1, 1, 0, 0, g);
    drive_cycle('1, '0, '1, 1, 0, 0, g);
    repeat (5) drive_cycle('1, '0, '1, 0, 0, 0, g);

    // Req1 on empty VC1 vs req2 on VC2 with 5 credits
    repeat (2) drive_cycle('0, '0, '1, 0, 0, 1, g);
    repeat (8) drive_cycle(4'b0010, 8'h24, '1, 0, 0, 0, g);
    repeat (3) drive_cycle(4'b0100, 8'h24, '1, 0, 0, 0, g);
    repeat (7) drive_cycle(4'b0110, 8'h24, '1, 0, 0, 0, g);
    drive_cycle(4'b0110, 8'h24, '1, 1, 1, 0, g);
    repeat (2) drive_cycle(4'b0110, 8'h24, '1, 0, 0, 0, g);

    // Overflow on full VC3: sticky until reset
    drive_cycle('0, '0, '1, 1, 3, 0, g);
    repeat (3) drive_cycle('0, '0, '1, 0, 0, 0, g);
    repeat (2) drive_cycle('0, '0, '1, 0, 0, 1, g);
    drive_cycle('0, '0, '1, 0, 0, 0, g);

    // Req0 3-flit packet against req1 two single-flit packets
    s0 = 0; s1 = 0;
    for (int t = 0; t < 12 && (s0 < 3 || s1 < 2); t++) begin
      lst = 4'b1110;
      lst[0] = (s0 == 2);
      drive_cycle({2'b00, s1 < 2, s0 < 3}, '0, lst, 0, 0, 0, g);
      if (g == 0) s0++;
      if (g == 1) s1++;
    end
    chk("packet_done", cyc, FW'((s0 == 3) && (s1 == 2)), FW'(1));

    // Reset mid-packet, then fresh burst from requester 0 with full credits
    repeat (2) drive_cycle('0, '0, '1, 0, 0, 1, g);
    drive_cycle(4'b0011, '0, 4'b1110, 0, 0, 0, g);
    drive_cycle(4'b0011, '0, 4'b1110, 0, 0, 2, g);
    drive_cycle('1, '0, '1, 0, 0, 1, g);
    repeat (10) drive_cycle('1, '0, '1, 0, 0, 0, g);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      rm = 0;
      if ($urandom_range(0, 99) == 0) rm = 1;
      else if ($urandom_range(0, 99) == 0) rm = 2;
      drive_cycle(NUM_REQ'($urandom), (NUM_REQ*VC_BITS)'($urandom),
                  NUM_REQ'($urandom | $urandom), 1'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, NUM_VCS-1)), rm, g);
    end
    drive_cycle('0, '0, '1, 0, 0, 0, g);

    @(negedge CLK);
    #1;
    chk("queue_drained", cyc, FW'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
